// File: rtl/layer_0_maxpool.sv
// Streaming 2x2 / stride-2 max-pool over one IEEE-754 channel, raster in, raster out.
// Define MAXPOOL_RELU_EN to clamp negative pooled results (including -0) to +0.
module layer_0_maxpool #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_SIZE   = 416
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  frame_done
);
    localparam int HALF = IMG_SIZE / 2;
    localparam int CW   = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
    localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);

    // True only when b is strictly greater, so ties keep the earlier operand a.
    function automatic logic right_wins(input logic [DATA_WIDTH-1:0] a,
                                        input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-2:0] ma;
        logic [DATA_WIDTH-2:0] mb;
        ma = a[DATA_WIDTH-2:0];
        mb = b[DATA_WIDTH-2:0];
        if (ma == '0 && mb == '0)
            return 1'b0;
        if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
            return a[DATA_WIDTH-1];
        if (!a[DATA_WIDTH-1])
            return mb > ma;
        return mb < ma;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        return right_wins(a, b) ? b : a;
    endfunction

    logic [CW-1:0]         col_q, col_d;
    logic [CW-1:0]         row_q, row_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  frame_done_q, frame_done_d;

    logic [DATA_WIDTH-1:0] linebuf_q [HALF];
    logic [IW-1:0]         lb_idx;
    logic                  lb_we;
    logic [DATA_WIDTH-1:0] pair_max;
    logic [DATA_WIDTH-1:0] pooled;
    logic [DATA_WIDTH-1:0] pooled_act;

    always_comb begin
        lb_idx   = IW'(col_q >> 1);
        pair_max = fmax(hold_q, data_in);
        pooled   = fmax(linebuf_q[lb_idx], pair_max);
`ifdef MAXPOOL_RELU_EN
        pooled_act = pooled[DATA_WIDTH-1] ? '0 : pooled;
`else
        pooled_act = pooled;
`endif
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        data_out_d   = data_out_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;
        if (valid_in) begin
            if (!col_q[0]) begin
                hold_d = data_in;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                valid_out_d  = 1'b1;
                data_out_d   = pooled_act;
                frame_done_d = (col_q == LAST) && (row_q == LAST);
            end
            if (col_q == LAST) begin
                col_d = '0;
                row_d = (row_q == LAST) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Every entry is written on an even row before the odd row reads it, so no reset.
    always_ff @(posedge Clk) begin
        if (lb_we)
            linebuf_q[lb_idx] <= pair_max;
    end

    assign data_out   = data_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_layer_0_maxpool.sv
// Directed table-driven bench for layer_0_maxpool (4x4 frames) plus a randomized
// two-frame back-to-back run on a 16x16 instance against a key-ordering model.
module tb_layer_0_maxpool;
    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [31:0] d4 = '0, d16 = '0;
    logic        v4 = 1'b0, v16 = 1'b0;
    logic [31:0] do4, do16;
    logic        vo4, vo16, fd4, fd16;

    int n_cmp = 0;
    int n_bad = 0;

    layer_0_maxpool #(.DATA_WIDTH(32), .IMG_SIZE(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .data_in(d4), .valid_in(v4),
        .data_out(do4), .valid_out(vo4), .frame_done(fd4));

    layer_0_maxpool #(.DATA_WIDTH(32), .IMG_SIZE(16)) dut16 (
        .Clk(Clk), .Rst(Rst), .data_in(d16), .valid_in(v16),
        .data_out(do16), .valid_out(vo16), .frame_done(fd16));

    always #5 Clk = ~Clk;

    logic [32:0] q4[$];
    logic [32:0] q16[$];
    int          fd16_cnt = 0;

    always @(negedge Clk) begin
        if (vo4 === 1'b1) q4.push_back({fd4, do4});
        if (vo16 === 1'b1) q16.push_back({fd16, do16});
        if (fd16 === 1'b1) fd16_cnt++;
    end

    typedef struct packed {
        logic [15:0][31:0] pix;
        logic [3:0][31:0]  exp;
        logic [3:0]        gap;
    } vec_t;

`ifdef MAXPOOL_RELU_EN
    localparam logic [31:0] NEGZ_EXP = 32'h00000000;
`else
    localparam logic [31:0] NEGZ_EXP = 32'h80000000;
`endif

    logic [31:0] fa[16] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                            32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                            32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
    logic [31:0] fb[16] = '{32'hC0400000, 32'hBF800000, 32'h80000000, 32'h00000000,
                            32'hC0000000, 32'hC0A00000, 32'h80000000, 32'h00000000,
                            32'hC0800000, 32'h40000000, 32'h00000000, 32'hC1000000,
                            32'h3F000000, 32'h80000000, 32'h80000000, 32'hBF800000};
    vec_t tbl[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic beat4(input logic [31:0] d);
        v4 = 1'b1; d4 = d;
        @(posedge Clk); #1;
        v4 = 1'b0;
    endtask

    task automatic beat16(input logic [31:0] d);
        v16 = 1'b1; d16 = d;
        @(posedge Clk); #1;
        v16 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge Clk); #1; end
    endtask

    task automatic run_frame(input int k, input vec_t v);
        q4.delete();
        for (int i = 0; i < 16; i++) begin
            idle($urandom_range(0, int'(v.gap)));
            beat4(v.pix[i]);
        end
        idle(2);
        chk($sformatf("tbl%0d count", k), 32'(q4.size()), 32'd4);
        for (int j = 0; j < 4 && j < q4.size(); j++) begin
            chk($sformatf("tbl%0d win%0d data", k, j), q4[j][31:0], v.exp[j]);
            chk($sformatf("tbl%0d win%0d frame_done", k, j), 32'(q4[j][32]), (j == 3) ? 32'd1 : 32'd0);
        end
    endtask

    function automatic longint fkey(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] pick(input logic [31:0] a, input logic [31:0] b);
        return (fkey(b) > fkey(a)) ? b : a;
    endfunction

    logic [31:0] fr[512];
    logic [31:0] ref16[128];

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[0].pix[i] = fa[i];
            tbl[1].pix[i] = fb[i];
            tbl[2].pix[i] = fa[i];
            tbl[3].pix[i] = fb[i];
        end
        tbl[0].exp[0] = 32'h40C00000; tbl[0].exp[1] = 32'h41000000;
        tbl[0].exp[2] = 32'h41600000; tbl[0].exp[3] = 32'h41800000;
        tbl[1].exp[0] = 32'hBF800000; tbl[1].exp[1] = NEGZ_EXP;
        tbl[1].exp[2] = 32'h40000000; tbl[1].exp[3] = 32'h00000000;
        tbl[2].exp = tbl[0].exp;
        tbl[3].exp = tbl[1].exp;
        tbl[0].gap = 4'd0; tbl[1].gap = 4'd0; tbl[2].gap = 4'd5; tbl[3].gap = 4'd3;

        // Asynchronous reset: outputs must clear before any clock edge.
        #1 Rst = 1'b1;
        #2;
        chk("reset data_out", do4, 32'h0);
        chk("reset valid_out", 32'(vo4), 32'h0);
        chk("reset frame_done", 32'(fd4), 32'h0);
        @(posedge Clk); @(posedge Clk); #1;
        Rst = 1'b0;

        // Latency, hold-when-idle, then abort mid-frame after 7 beats.
        for (int i = 0; i < 5; i++) beat4(fa[i]);
        chk("pre-window valid_out", 32'(vo4), 32'h0);
        beat4(fa[5]);
        chk("latency valid_out", 32'(vo4), 32'h1);
        chk("latency data_out", do4, 32'h40C00000);
        chk("latency frame_done", 32'(fd4), 32'h0);
        beat4(fa[6]);
        chk("hold valid_out", 32'(vo4), 32'h0);
        chk("hold data_out", do4, 32'h40C00000);
        Rst = 1'b1;
        #2;
        chk("midframe reset data_out", do4, 32'h0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        q4.delete();
        idle(3);
        chk("aborted frame outputs", 32'(q4.size()), 32'h0);
        run_frame(9, tbl[0]);

        for (int k = 0; k < 4; k++) run_frame(k, tbl[k]);

        // Two back-to-back random 16x16 frames.
        for (int i = 0; i < 512; i++) begin
            if ($urandom_range(0, 7) == 0)
                fr[i] = {1'($urandom_range(0, 1)), 31'h0};
            else
                fr[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), 23'($urandom)};
        end
        for (int f = 0; f < 2; f++)
            for (int wr = 0; wr < 8; wr++)
                for (int wc = 0; wc < 8; wc++) begin
                    int b;
                    logic [31:0] r;
                    b = f * 256 + wr * 32 + wc * 2;
                    r = pick(pick(fr[b], fr[b+1]), pick(fr[b+16], fr[b+17]));
`ifdef MAXPOOL_RELU_EN
                    if (r[31]) r = 32'h0;
`endif
                    ref16[f * 64 + wr * 8 + wc] = r;
                end
        q16.delete();
        fd16_cnt = 0;
        for (int i = 0; i < 512; i++) beat16(fr[i]);
        idle(2);
        chk("rand16 count", 32'(q16.size()), 32'd128);
        chk("rand16 frame_done pulses", 32'(fd16_cnt), 32'd2);
        for (int j = 0; j < 128 && j < q16.size(); j++) begin
            chk($sformatf("rand16 out%0d data", j), q16[j][31:0], ref16[j]);
            if (j == 63 || j == 127)
                chk($sformatf("rand16 out%0d frame_done", j), 32'(q16[j][32]), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
